// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - start/busy/done handshake and operand/result bus for seq_divider
interface seq_divider_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             dbz;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, dbz
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, dbz
    );
endinterface

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring divider, one trial subtraction per clock
// Optional two's complement operation is enabled by defining DIV_SIGNED_EN.
module seq_divider #(
    parameter int WIDTH = 4
) (
    input logic         clk,
    input logic         rst,
    seq_divider_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    count;

    logic [WIDTH+1:0] trial;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;

    logic [WIDTH-1:0] dvd_in;
    logic [WIDTH-1:0] dvs_in;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             dbz_r;

    logic             accept;
    logic             div_zero;

    assign accept   = bus.start && (state != BUSY);
    assign div_zero = (bus.divisor == '0);

    // One restoring step: the sign bit of the widened trial decides keep vs restore.
    always_comb begin
        trial    = {rem, quo[WIDTH-1]} - {2'b00, dvs};
        rem_next = trial[WIDTH:0];
        quo_next = {quo[WIDTH-2:0], 1'b1};
        if (trial[WIDTH+1]) begin
            rem_next = {rem[WIDTH-1:0], quo[WIDTH-1]};
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

`ifdef DIV_SIGNED_EN
    logic neg_q;
    logic neg_r;

    assign dvd_in = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    assign dvs_in = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
    // Most-negative / -1 wraps naturally: magnitude 2^(WIDTH-1) negated is itself.
    assign q_fix  = neg_q ? -quo_next : quo_next;
    assign r_fix  = neg_r ? -rem_next[WIDTH-1:0] : rem_next[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            neg_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            neg_r <= bus.dividend[WIDTH-1];
        end
    end
`else
    assign dvd_in = bus.dividend;
    assign dvs_in = bus.divisor;
    assign q_fix  = quo_next;
    assign r_fix  = rem_next[WIDTH-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            state_nxt = div_zero ? DONE : BUSY;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                BUSY:    if (count == LAST) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Result registers change only on entry to DONE, so they hold through the next BUSY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem         <= '0;
            quo         <= '0;
            dvs         <= '0;
            count       <= '0;
            quotient_r  <= '0;
            remainder_r <= '0;
            dbz_r       <= 1'b0;
        end else if (accept) begin
            rem   <= '0;
            quo   <= dvd_in;
            dvs   <= dvs_in;
            count <= '0;
            if (div_zero) begin
                quotient_r  <= '1;
                remainder_r <= bus.dividend;
                dbz_r       <= 1'b1;
            end else begin
                dbz_r       <= 1'b0;
            end
        end else if (state == BUSY) begin
            rem   <= rem_next;
            quo   <= quo_next;
            count <= count + 1'b1;
            if (count == LAST) begin
                quotient_r  <= q_fix;
                remainder_r <= r_fix;
            end
        end
    end

    assign bus.busy      = (state == BUSY);
    assign bus.done      = (state == DONE);
    assign bus.quotient  = quotient_r;
    assign bus.remainder = remainder_r;
    assign bus.dbz       = dbz_r;
endmodule
